// File: rtl/regfile_pkg.sv
// Shared defaults and port-slice helpers for the pipelined CPU register file.
package regfile_pkg;

  localparam int         DEF_DATA_W = 32;
  localparam int         DEF_ADDR_W = 5;
  localparam logic [4:0] REG_ZERO   = 5'd0;

  // Bit offset of port `port` inside a flattened bus of `width`-bit fields.
  function automatic int slice_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at writeback.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_RD      = 2,
  parameter int WRITE_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        rbusy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit WF    = (WRITE_FIRST != 0);

  logic [DEPTH-1:0] r_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      // NOTE: both updates are non-blocking; the later set overrides the earlier clear
      // for the same bit, so a freshly issued producer is never lost to a retiring one.
      if (we) r_pend[waddr] <= 1'b0;
      if (pend_set && (pend_addr != ADDR_W'(REG_ZERO))) r_pend[pend_addr] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_busy
    logic [ADDR_W-1:0] w_addr;
    logic              w_fwd;

    assign w_addr   = raddr[slice_lsb(g, ADDR_W) +: ADDR_W];
    assign w_fwd    = WF && we && (waddr == w_addr);
    // A producer retiring this cycle is forwarded, so it no longer blocks decode.
    assign rbusy[g] = r_pend[w_addr] && !w_fwd;
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-port register file with write-first forwarding and a pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_RD      = 2,
  parameter int WRITE_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit WF    = (WRITE_FIRST != 0);

  logic [DATA_W-1:0] r_rf [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole array is cleared because reads must return 0 after reset;
      // this keeps the storage in flops rather than letting it map to a RAM macro.
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
    end else if (we && (waddr != ADDR_W'(REG_ZERO))) begin
      r_rf[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_fwd;

    assign w_addr = raddr[slice_lsb(g, ADDR_W) +: ADDR_W];
    assign w_fwd  = WF && we && (waddr == w_addr);
    assign rdata[slice_lsb(g, DATA_W) +: DATA_W] =
        (w_addr == ADDR_W'(REG_ZERO)) ? '0    :
        w_fwd                         ? wdata :
                                        r_rf[w_addr];
  end

  rf_scoreboard #(
    .ADDR_W      (ADDR_W),
    .NUM_RD      (NUM_RD),
    .WRITE_FIRST (WRITE_FIRST)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .pend_set  (pend_set),
    .pend_addr (pend_addr),
    .we        (we),
    .waddr     (waddr),
    .raddr     (raddr),
    .rbusy     (rbusy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised + directed bench: a write-first 32-bit/2-port file and a read-old 64-bit/4-port
// file share one stimulus stream and are compared against an array-based reference model.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, pend_set;
  logic [4:0]  waddr, pend_addr;
  logic [63:0] wdata;
  logic [4:0]  ra [4];

  logic [9:0]   raddr_a;
  logic [19:0]  raddr_b;
  logic [63:0]  rdata_a;
  logic [1:0]   rbusy_a;
  logic [255:0] rdata_b;
  logic [3:0]   rbusy_b;

  assign raddr_a = {ra[1], ra[0]};
  assign raddr_b = {ra[3], ra[2], ra[1], ra[0]};

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .WRITE_FIRST(1)) u_dut_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata[31:0]),
    .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
    .pend_set(pend_set), .pend_addr(pend_addr)
  );

  regfile_sb #(.DATA_W(64), .ADDR_W(5), .NUM_RD(4), .WRITE_FIRST(0)) u_dut_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
    .pend_set(pend_set), .pend_addr(pend_addr)
  );

  // Reference model: register contents and outstanding-write flags.
  logic [63:0] mem  [32];
  bit          pend [32];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ports();
    logic [63:0] exp;
    bit          fwd;
    for (int i = 0; i < 2; i++) begin
      fwd = we && (waddr == ra[i]) && (ra[i] != 0);
      exp = (ra[i] == 0) ? 64'h0 : fwd ? {32'h0, wdata[31:0]} : {32'h0, mem[ra[i]][31:0]};
      check($sformatf("A rdata%0d r%0d", i, ra[i]), {32'h0, rdata_a[i*32 +: 32]}, exp);
      check($sformatf("A rbusy%0d r%0d", i, ra[i]), {63'h0, rbusy_a[i]},
            {63'h0, pend[ra[i]] && !fwd});
    end
    for (int i = 0; i < 4; i++) begin
      exp = (ra[i] == 0) ? 64'h0 : mem[ra[i]];
      check($sformatf("B rdata%0d r%0d", i, ra[i]), rdata_b[i*64 +: 64], exp);
      check($sformatf("B rbusy%0d r%0d", i, ra[i]), {63'h0, rbusy_b[i]}, {63'h0, pend[ra[i]]});
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem[i]  = 64'h0;
        pend[i] = 1'b0;
      end
    end else begin
      if (we && waddr != 0) mem[waddr] = wdata;
      if (we) pend[waddr] = 1'b0;
      if (pend_set && pend_addr != 0) pend[pend_addr] = 1'b1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    if (chk_en) check_ports();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc();
    settle();
    clk_edge();
  endtask

  task automatic quiet();
    rst = 1'b0; we = 1'b0; pend_set = 1'b0;
  endtask

  task automatic set_ra(input logic [4:0] a);
    for (int i = 0; i < 4; i++) ra[i] = a;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]  = 64'h0;
      pend[i] = 1'b0;
    end
    rst = 1'b1; we = 1'b0; pend_set = 1'b0;
    waddr = '0; pend_addr = '0; wdata = '0;
    set_ra(5'd0);
    clk_edge();
    clk_edge();
    quiet();
    chk_en = 1'b1;

    // Reset state on every register, then r0 write is dropped.
    for (int a = 0; a < 32; a++) begin
      set_ra(5'(a));
      cyc();
    end
    set_ra(5'd0);
    we = 1'b1; waddr = 5'd0; wdata = '1;
    settle();
    check("t1 r0 same cycle", {32'h0, rdata_a[31:0]}, 64'h0);
    clk_edge();
    quiet();
    settle();
    check("t1 r0 after A", {32'h0, rdata_a[31:0]}, 64'h0);
    check("t1 r0 after B", rdata_b[63:0], 64'h0);
    clk_edge();

    // Write-first vs read-old on a same-cycle write.
    we = 1'b1; waddr = 5'd5; wdata = 64'hCAFE_F00D_DEAD_BEEF; ra[0] = 5'd5;
    settle();
    check("t2 A fwd", {32'h0, rdata_a[31:0]}, 64'h0000_0000_DEAD_BEEF);
    check("t2 B old", rdata_b[63:0], 64'h0);
    clk_edge();
    quiet();
    settle();
    check("t2 A next", {32'h0, rdata_a[31:0]}, 64'h0000_0000_DEAD_BEEF);
    check("t2 B next", rdata_b[63:0], 64'hCAFE_F00D_DEAD_BEEF);
    clk_edge();

    // Pending write on r7, then its retirement.
    pend_set = 1'b1; pend_addr = 5'd7; ra[1] = 5'd7;
    cyc();
    quiet();
    repeat (3) begin
      settle();
      check("t3 A busy", {63'h0, rbusy_a[1]}, 64'h1);
      check("t3 B busy", {63'h0, rbusy_b[1]}, 64'h1);
      clk_edge();
    end
    we = 1'b1; waddr = 5'd7; wdata = 64'h12;
    settle();
    check("t3 A retire busy", {63'h0, rbusy_a[1]}, 64'h0);
    check("t3 A retire data", {32'h0, rdata_a[63:32]}, 64'h12);
    check("t3 B retire busy", {63'h0, rbusy_b[1]}, 64'h1);
    clk_edge();
    quiet();
    settle();
    check("t3 A cleared", {63'h0, rbusy_a[1]}, 64'h0);
    check("t3 B cleared", {63'h0, rbusy_b[1]}, 64'h0);
    check("t3 B data", rdata_b[127:64], 64'h12);
    clk_edge();

    // Set wins over clear on r9; pend_set to r0 is ignored.
    pend_set = 1'b1; pend_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 64'h99; ra[0] = 5'd9;
    cyc();
    quiet();
    settle();
    check("t4 r9 pend", {63'h0, rbusy_a[0]}, 64'h1);
    check("t4 r9 data", {32'h0, rdata_a[31:0]}, 64'h99);
    clk_edge();
    pend_set = 1'b1; pend_addr = 5'd0; ra[0] = 5'd0;
    cyc();
    quiet();
    settle();
    check("t4 r0 pend", {63'h0, rbusy_a[0]}, 64'h0);
    clk_edge();

    // Reset mid-operation with a coincident write.
    for (int k = 1; k <= 3; k++) begin
      we = 1'b1; waddr = 5'(k); wdata = 64'h100 + 64'(k);
      pend_set = (k == 3); pend_addr = 5'd4;
      cyc();
    end
    quiet();
    rst = 1'b1; we = 1'b1; waddr = 5'd2; wdata = 64'hBAD;
    ra[0] = 5'd1; ra[1] = 5'd3; ra[2] = 5'd4; ra[3] = 5'd3;
    cyc();
    quiet();
    for (int a = 0; a < 32; a++) begin
      set_ra(5'(a));
      settle();
      check("t5 A data", {32'h0, rdata_a[31:0]}, 64'h0);
      check("t5 A busy", {62'h0, rbusy_a}, 64'h0);
      check("t5 B data", rdata_b[255:192], 64'h0);
      clk_edge();
    end

    // Four distinct ports, then two aliased ports.
    for (int k = 10; k <= 13; k++) begin
      we = 1'b1; waddr = 5'(k); wdata = {32'(k), 32'(k) ^ 32'hA5A5_0000};
      cyc();
    end
    quiet();
    ra[0] = 5'd10; ra[1] = 5'd11; ra[2] = 5'd12; ra[3] = 5'd13;
    settle();
    for (int i = 0; i < 4; i++)
      check($sformatf("t6 distinct p%0d", i), rdata_b[i*64 +: 64],
            {32'(10 + i), 32'(10 + i) ^ 32'hA5A5_0000});
    clk_edge();
    ra[1] = 5'd12;
    settle();
    check("t6 alias p1", rdata_b[127:64], {32'd12, 32'd12 ^ 32'hA5A5_0000});
    check("t6 alias p2", rdata_b[191:128], {32'd12, 32'd12 ^ 32'hA5A5_0000});
    check("t6 alias p0", rdata_b[63:0], {32'd10, 32'd10 ^ 32'hA5A5_0000});
    clk_edge();

    // Random traffic with clustered addresses to provoke collisions.
    repeat (3000) begin
      rst       = ($urandom_range(0, 99) < 2);
      we        = ($urandom_range(0, 1) == 1);
      waddr     = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      wdata     = {$urandom, $urandom};
      pend_set  = ($urandom_range(0, 9) < 4);
      pend_addr = 5'($urandom_range(0, 7));
      for (int i = 0; i < 4; i++)
        ra[i] = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
